// File: rtl/seq_mul_nxn.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mul_nxn
//  Purpose  : Sequential unsigned W x W multiplier (W = CHUNK*NCHUNK). Each
//             enabled RUN cycle takes one CHUNK x CHUNK partial product and
//             adds it, shifted into place, to a 2W-bit accumulator. The
//             current chunk-select and shift codes are exported for the
//             display and debug paths.
//  Ports    : clk        - clock, all state on the rising edge
//             rst        - asynchronous, active-low reset
//             start      - request a multiply (sampled in IDLE/DONE only)
//             step_en    - pacing enable, one partial product per enabled cycle
//             a, b       - W-bit operands, captured on the accepting edge
//             product    - 2W-bit registered result, updated on completion
//             busy       - high while in RUN
//             done       - high in DONE until the next accepted start
//             done_pulse - one-cycle pulse on the edge entering DONE
//             sel_a      - a-chunk index of the current partial product
//             sel_b      - b-chunk index of the current partial product
//             shift_sel  - chunk shift of the current partial product
//  Revision : 1.0 - initial release, replaces fixed 8x8 four-step controller
// ============================================================================
module seq_mul_nxn #(
    parameter  int CHUNK  = 4,
    parameter  int NCHUNK = 2,
    localparam int W      = CHUNK * NCHUNK,
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
    localparam int SW     = ((2 * NCHUNK - 1) > 1) ? $clog2(2 * NCHUNK - 1) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step_en,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic [2*W-1:0]  product,
    output logic            busy,
    output logic            done,
    output logic            done_pulse,
    output logic [CW-1:0]   sel_a,
    output logic [CW-1:0]   sel_b,
    output logic [SW-1:0]   shift_sel
);

    localparam int PW  = 2 * W;      // accumulator / product width
    localparam int PPW = 2 * CHUNK;  // partial product width

    localparam logic [CW-1:0] C_LAST_SEL = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_product;
    logic            r_done_pulse;
    // The step counter k is held as its (k / NCHUNK, k % NCHUNK) digit pair,
    // so the selects come straight from registers and no divider is needed.
    logic [CW-1:0]   r_sel_a;
    logic [CW-1:0]   r_sel_b;

    logic            w_accept;
    logic            w_step;
    logic            w_last;
    logic [CHUNK-1:0] w_chunk_a;
    logic [CHUNK-1:0] w_chunk_b;
    logic [PPW-1:0]  w_pp;
    logic [SW-1:0]   w_shift_sel;
    logic [PW-1:0]   w_term;
    logic [PW-1:0]   w_acc_next;

    assign w_accept = start && (r_state != S_RUN);
    assign w_step   = step_en && (r_state == S_RUN);
    assign w_last   = (r_sel_a == C_LAST_SEL) && (r_sel_b == C_LAST_SEL);

    assign w_chunk_a   = r_a[r_sel_a * CHUNK +: CHUNK];
    assign w_chunk_b   = r_b[r_sel_b * CHUNK +: CHUNK];
    assign w_pp        = PPW'(w_chunk_a) * PPW'(w_chunk_b);
    assign w_shift_sel = SW'(r_sel_a) + SW'(r_sel_b);
    assign w_term      = PW'(w_pp) << (w_shift_sel * CHUNK);
    assign w_acc_next  = r_acc + w_term;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)                w_state_next = S_RUN;
            S_RUN:   if (w_step && w_last)     w_state_next = S_DONE;
            S_DONE:  if (start)                w_state_next = S_RUN;
            default:                           w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture, chunk stepping and accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_product    <= '0;
            r_done_pulse <= 1'b0;
            r_sel_a      <= '0;
            r_sel_b      <= '0;
        end else begin
            r_done_pulse <= 1'b0;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_acc   <= '0;
                r_sel_a <= '0;
                r_sel_b <= '0;
            end else if (w_step) begin
                r_acc <= w_acc_next;
                if (w_last) begin
                    // Selects return to zero so they read 0 while in DONE.
                    r_product    <= w_acc_next;
                    r_done_pulse <= 1'b1;
                    r_sel_a      <= '0;
                    r_sel_b      <= '0;
                end else if (r_sel_b == C_LAST_SEL) begin
                    r_sel_b <= '0;
                    r_sel_a <= r_sel_a + CW'(1);
                end else begin
                    r_sel_b <= r_sel_b + CW'(1);
                end
            end
        end
    end

    assign product    = r_product;
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign done_pulse = r_done_pulse;
    assign sel_a      = r_sel_a;
    assign sel_b      = r_sel_b;
    assign shift_sel  = w_shift_sel;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_nxn.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_mul_nxn
//  Purpose  : Self-checking bench for seq_mul_nxn. Expected products are
//             queued when a multiply is launched and compared when the DUT
//             pulses done_pulse. An 8x8 (CHUNK=4, NCHUNK=2) and a 16x16
//             (CHUNK=4, NCHUNK=4) instance are exercised.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mul_nxn;

    logic        clk;
    logic        rst;
    logic        start;
    logic        step_en;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic        busy;
    logic        done;
    logic        done_pulse;
    logic [0:0]  sel_a;
    logic [0:0]  sel_b;
    logic [1:0]  shift_sel;

    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [31:0] product16;
    logic        busy16;
    logic        done16;
    logic        done_pulse16;
    logic [1:0]  sel_a16;
    logic [1:0]  sel_b16;
    logic [2:0]  shift_sel16;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [31:0] exp_q16[$];
    logic [15:0] last_prod;

    seq_mul_nxn #(.CHUNK(4), .NCHUNK(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step_en    (step_en),
        .a          (a),
        .b          (b),
        .product    (product),
        .busy       (busy),
        .done       (done),
        .done_pulse (done_pulse),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .shift_sel  (shift_sel)
    );

    seq_mul_nxn #(.CHUNK(4), .NCHUNK(4)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .start      (start16),
        .step_en    (step_en),
        .a          (a16),
        .b          (b16),
        .product    (product16),
        .busy       (busy16),
        .done       (done16),
        .done_pulse (done_pulse16),
        .sel_a      (sel_a16),
        .sel_b      (sel_b16),
        .shift_sel  (shift_sel16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every completion pops one expected product.
    always begin
        @(posedge clk);
        #2;
        if (done_pulse) begin
            if (exp_q.size() == 0) check("unexpected done_pulse", 64'd1, 64'd0);
            else check("scoreboard product", 64'(product), 64'(exp_q.pop_front()));
        end
        if (done_pulse16) begin
            if (exp_q16.size() == 0) check("unexpected done_pulse16", 64'd1, 64'd0);
            else check("scoreboard product16", 64'(product16), 64'(exp_q16.pop_front()));
        end
    end

    // One 8x8 multiply. toggle: step_en alternates 1,0,1,... ; glitch: RUN
    // cycle on which a stray start with other operands is driven (-1 = none).
    task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input bit toggle,
                          input int glitch, input int exp_lat, input string tag);
        int k;
        int cyc;
        bit en;
        logic [15:0] exp_p;
        exp_p = {8'd0, aa} * {8'd0, bb};
        a = aa; b = bb; start = 1'b1; step_en = 1'b1;
        exp_q.push_back(exp_p);
        tick();
        start = 1'b0;
        check({tag, " busy@E0"}, 64'(busy), 64'd1);
        check({tag, " done@E0"}, 64'(done), 64'd0);
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 64) begin
            check({tag, " sel_a"},     64'(sel_a),     64'(k / 2));
            check({tag, " sel_b"},     64'(sel_b),     64'(k % 2));
            check({tag, " shift_sel"}, 64'(shift_sel), 64'(k / 2 + k % 2));
            check({tag, " product hold"}, 64'(product), 64'(last_prod));
            check({tag, " busy"},      64'(busy),      64'd1);
            en = toggle ? (cyc % 2 == 0) : 1'b1;
            step_en = en;
            if (cyc == glitch) begin
                start = 1'b1; a = ~aa; b = bb ^ 8'h5A;
            end
            tick();
            cyc++;
            start = 1'b0; a = aa; b = bb;
            if (en) k++;
        end
        check({tag, " latency"},    64'(cyc),        64'(exp_lat));
        check({tag, " done"},       64'(done),       64'd1);
        check({tag, " busy end"},   64'(busy),       64'd0);
        check({tag, " done_pulse"}, 64'(done_pulse), 64'd1);
        check({tag, " sel idle"},   64'({sel_a, sel_b, shift_sel}), 64'd0);
        check({tag, " product"},    64'(product),    64'(exp_p));
        last_prod = exp_p;
        tick();
        check({tag, " pulse drop"}, 64'(done_pulse), 64'd0);
        check({tag, " done held"},  64'(done),       64'd1);
    endtask

    initial begin
        int cyc;
        int k;
        int peak;
        rst = 1'b0; start = 1'b0; step_en = 1'b0; a = '0; b = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        last_prod = '0;
        #3;
        check("reset product", 64'(product), 64'd0);
        check("reset flags", 64'({busy, done, done_pulse}), 64'd0);
        check("reset sels", 64'({sel_a, sel_b, shift_sel}), 64'd0);
        check("reset product16", 64'(product16), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick();

        run_op(8'hFF, 8'hFF, 1'b0, -1, 4, "t1");
        run_op(8'h3C, 8'hA5, 1'b1, -1, 7, "t2");
        run_op(8'h00, 8'h77, 1'b0, -1, 4, "t3");
        run_op(8'h9B, 8'hE7, 1'b0,  2, 4, "t4");

        // Asynchronous reset during the third step of a multiply.
        a = 8'hAB; b = 8'hCD; start = 1'b1; step_en = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("async rst product", 64'(product), 64'd0);
        check("async rst flags", 64'({busy, done, done_pulse}), 64'd0);
        check("async rst sels", 64'({sel_a, sel_b, shift_sel}), 64'd0);
        last_prod = '0;
        tick();
        rst = 1'b1;
        tick();
        run_op(8'h12, 8'h34, 1'b0, -1, 4, "t5");

        // 16x16 instance: 16 steps, shift peaks at 3+3.
        a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1; step_en = 1'b1;
        exp_q16.push_back(32'hFFFE0001);
        tick();
        start16 = 1'b0;
        cyc = 0; k = 0; peak = 0;
        while (!done16 && cyc < 100) begin
            check("w16 shift_sel", 64'(shift_sel16), 64'(k / 4 + k % 4));
            if (int'(shift_sel16) > peak) peak = int'(shift_sel16);
            tick();
            cyc++;
            k++;
        end
        check("w16 latency", 64'(cyc), 64'd16);
        check("w16 shift peak", 64'(peak), 64'd6);
        check("w16 product", 64'(product16), 64'h0000_0000_FFFE_0001);

        tick();
        tick();
        check("queue drained", 64'(exp_q.size()), 64'd0);
        check("queue16 drained", 64'(exp_q16.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
